lsu_mem_stage: RTL

- Memory stage directly downstream of the execute-stage ALU in the RV32I_Zicsr pipeline.
- Consumes the ALU result as the effective address and rs2 as store data, and performs one data-memory transaction per accepted instruction.
- Returns sign- or zero-extended load data, or the unchanged ALU result, to writeback.
- Stalls execute while a transaction is outstanding; flags misaligned, illegal-width and bus-timeout faults.

---
 rtl/lsu_mem_stage.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage
//   Memory stage that sits directly after the execute-stage ALU of an
//   RV32I_Zicsr pipeline. The ALU result is used as the effective address
//   and rs2 as store data. Each accepted instruction performs at most one
//   data-memory transaction. The stage returns sign- or zero-extended load
//   data, or the unchanged ALU result, to writeback. Execute is stalled
//   (ow_ready low) while a transaction is outstanding. Misaligned accesses,
//   illegal widths and bus timeouts are reported as one-cycle fault pulses.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / ow_ready    execute handshake (ow_ready is high only in IDLE)
//   i_result, i_rs2       ALU result (address or wb value), store data
//   i_funct3, i_opcode    access width/sign, instruction class
//   i_rd_addr             destination register
//   or_mem_*              bus request: req, we, word address, wdata, wstrb
//   i_mem_ack/i_mem_rdata bus completion and read word
//   or_wb_*               one-cycle writeback pulse with rd and data
//   or_fault*             one-cycle fault pulse: cause and faulting address
//                         (01 misaligned, 10 illegal width, 11 bus timeout)
// ----------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            ow_ready,
    input  logic [XLEN-1:0] i_result,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_opcode,
    input  logic [4:0]      i_rd_addr,
    output logic            or_mem_req,
    output logic            or_mem_we,
    output logic [XLEN-1:0] or_mem_addr,
    output logic [XLEN-1:0] or_mem_wdata,
    output logic [3:0]      or_mem_wstrb,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            or_wb_valid,
    output logic [4:0]      or_wb_rd_addr,
    output logic [XLEN-1:0] or_wb_data,
    output logic            or_fault,
    output logic [1:0]      or_fault_cause,
    output logic [XLEN-1:0] or_fault_addr
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Byte strobes for a store; funct3[1:0] selects B/H/W.
    function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   f_wstrb = 4'b0001 << off;
            2'b01:   f_wstrb = 4'b0011 << off;
            default: f_wstrb = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane so the strobes pick the slot.
    function automatic logic [XLEN-1:0] f_wdata(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
        case (f3[1:0])
            2'b00:   f_wdata = {4{rs2[7:0]}};
            2'b01:   f_wdata = {2{rs2[15:0]}};
            default: f_wdata = rs2;
        endcase
    endfunction

    // Pick the addressed lane from the read word and extend it.
    function automatic logic [XLEN-1:0] f_load_ext(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  f_load_ext = {{24{b[7]}}, b};
            3'b001:  f_load_ext = {{16{h[15]}}, h};
            3'b100:  f_load_ext = {24'b0, b};
            3'b101:  f_load_ext = {16'b0, h};
            default: f_load_ext = rdata;
        endcase
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_cnt;
    logic [TW-1:0]   w_cnt_nxt;
    logic [XLEN-1:0] r_ea;
    logic [XLEN-1:0] w_ea_nxt;
    logic [2:0]      r_funct3;
    logic [2:0]      w_funct3_nxt;
    logic            r_is_load;
    logic            w_is_load_nxt;
    logic [4:0]      r_rd;
    logic [4:0]      w_rd_nxt;

    logic            w_mem_req_nxt;
    logic            w_mem_we_nxt;
    logic [XLEN-1:0] w_mem_addr_nxt;
    logic [XLEN-1:0] w_mem_wdata_nxt;
    logic [3:0]      w_mem_wstrb_nxt;
    logic            w_wb_valid_nxt;
    logic [4:0]      w_wb_rd_nxt;
    logic [XLEN-1:0] w_wb_data_nxt;
    logic            w_fault_nxt;
    logic [1:0]      w_fault_cause_nxt;
    logic [XLEN-1:0] w_fault_addr_nxt;

    logic w_accept;
    logic w_is_load;
    logic w_is_store;
    logic w_illegal;
    logic w_misalign;

    assign ow_ready   = (r_state == S_IDLE);
    assign w_accept   = i_valid && ow_ready;
    assign w_is_load  = (i_opcode == OP_LOAD);
    assign w_is_store = (i_opcode == OP_STORE);

    assign w_illegal = (w_is_load  && (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111)) ||
                       (w_is_store && (i_funct3[2] || i_funct3 == 3'b011));

    // Only evaluated once illegal widths are excluded, so [1:0]==10 means W.
    assign w_misalign = (i_funct3[1:0] == 2'b01 && i_result[0]) ||
                        (i_funct3[1:0] == 2'b10 && i_result[1:0] != 2'b00);

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_ea_nxt          = r_ea;
        w_funct3_nxt      = r_funct3;
        w_is_load_nxt     = r_is_load;
        w_rd_nxt          = r_rd;
        w_mem_req_nxt     = or_mem_req;
        w_mem_we_nxt      = or_mem_we;
        w_mem_addr_nxt    = or_mem_addr;
        w_mem_wdata_nxt   = or_mem_wdata;
        w_mem_wstrb_nxt   = or_mem_wstrb;
        w_wb_valid_nxt    = 1'b0;
        w_wb_rd_nxt       = or_wb_rd_addr;
        w_wb_data_nxt     = or_wb_data;
        w_fault_nxt       = 1'b0;
        w_fault_cause_nxt = or_fault_cause;
        w_fault_addr_nxt  = or_fault_addr;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_load && !w_is_store) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_data_nxt  = i_result;
                        w_wb_rd_nxt    = i_rd_addr;
                    end else if (w_illegal) begin
                        w_fault_nxt       = 1'b1;
                        w_fault_cause_nxt = CAUSE_ILLEGAL;
                        w_fault_addr_nxt  = i_result;
                    end else if (w_misalign) begin
                        w_fault_nxt       = 1'b1;
                        w_fault_cause_nxt = CAUSE_MISALIGN;
                        w_fault_addr_nxt  = i_result;
                    end else begin
                        w_ea_nxt        = i_result;
                        w_funct3_nxt    = i_funct3;
                        w_is_load_nxt   = w_is_load;
                        w_rd_nxt        = i_rd_addr;
                        w_cnt_nxt       = '0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = w_is_store;
                        w_mem_addr_nxt  = {i_result[XLEN-1:2], 2'b00};
                        w_mem_wdata_nxt = w_is_store ? f_wdata(i_funct3, i_rs2) : '0;
                        w_mem_wstrb_nxt = w_is_store ? f_wstrb(i_funct3, i_result[1:0]) : 4'b0000;
                        w_state_nxt     = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // Ack is tested first so it wins over a simultaneous timeout.
                if (i_mem_ack) begin
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_wstrb_nxt = 4'b0000;
                    w_cnt_nxt       = '0;
                    if (r_is_load) begin
                        w_wb_data_nxt = f_load_ext(r_funct3, r_ea[1:0], i_mem_rdata);
                    end
                    w_state_nxt = S_RESP;
                end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                    w_mem_req_nxt     = 1'b0;
                    w_mem_we_nxt      = 1'b0;
                    w_mem_wstrb_nxt   = 4'b0000;
                    w_cnt_nxt         = '0;
                    w_fault_nxt       = 1'b1;
                    w_fault_cause_nxt = CAUSE_TIMEOUT;
                    w_fault_addr_nxt  = r_ea;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TW'(1);
                end
            end
            S_RESP: begin
                w_wb_valid_nxt = r_is_load;
                w_wb_rd_nxt    = r_rd;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_ea           <= '0;
            r_funct3       <= '0;
            r_is_load      <= 1'b0;
            r_rd           <= '0;
            or_mem_req     <= 1'b0;
            or_mem_we      <= 1'b0;
            or_mem_addr    <= '0;
            or_mem_wdata   <= '0;
            or_mem_wstrb   <= '0;
            or_wb_valid    <= 1'b0;
            or_wb_rd_addr  <= '0;
            or_wb_data     <= '0;
            or_fault       <= 1'b0;
            or_fault_cause <= '0;
            or_fault_addr  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ea           <= w_ea_nxt;
            r_funct3       <= w_funct3_nxt;
            r_is_load      <= w_is_load_nxt;
            r_rd           <= w_rd_nxt;
            or_mem_req     <= w_mem_req_nxt;
            or_mem_we      <= w_mem_we_nxt;
            or_mem_addr    <= w_mem_addr_nxt;
            or_mem_wdata   <= w_mem_wdata_nxt;
            or_mem_wstrb   <= w_mem_wstrb_nxt;
            or_wb_valid    <= w_wb_valid_nxt;
            or_wb_rd_addr  <= w_wb_rd_nxt;
            or_wb_data     <= w_wb_data_nxt;
            or_fault       <= w_fault_nxt;
            or_fault_cause <= w_fault_cause_nxt;
            or_fault_addr  <= w_fault_addr_nxt;
        end
    end

endmodule
